// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control blocks: sequencer states,
// instruction-word field positions and the injected INT pseudo-instruction.
package pipe_pkg;

  // Interrupt sequencer states, in the order a request walks through them.
  typedef enum logic [2:0] {
    IDLE,
    BOUNDARY,
    DRAIN,
    INJECT,
    WAIT_ACK,
    VECTOR
  } intr_state_t;

  // Bit positions of the control fields in the 16-bit instruction word.
  localparam int INT_BIT           = 15;
  localparam int PC_FLAGS_SAVE_BIT = 14;
  localparam int FLAGS_RESTORE_BIT = 7;
  localparam int INT_AUX_BIT       = 6;

  // INT pseudo-instruction: only the control field bits above are set,
  // which gives 16'hC0C0.
  localparam logic [15:0] INT_OPCODE = 16'((1 << INT_BIT)
                                          | (1 << PC_FLAGS_SAVE_BIT)
                                          | (1 << FLAGS_RESTORE_BIT)
                                          | (1 << INT_AUX_BIT));

endpackage

// File: rtl/intr_sync.sv
// Brings the asynchronous INT pin into the clock domain and turns each
// rising level into a single-cycle pulse.
module intr_sync (
  input  logic clk,
  input  logic rst,
  input  logic intr_in,
  output logic edge_pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // Two-flop synchronizer followed by one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= intr_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign edge_pulse = sync & ~sync_d;

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt sequencer: latches a request, waits for a safe instruction
// boundary, freezes and drains fetch, injects the INT word into decode,
// waits for decode to acknowledge it, then loads the vector into the PC
// and blocks nesting until RTI.
module intr_sequencer
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned ACK_TIMEOUT  = 8,
  parameter logic [9:0]  VECTOR_ADDR  = 10'd1,
  parameter logic [15:0] INT_WORD     = INT_OPCODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr_in,
  input  logic        imm_pending,
  input  logic        branch_taken,
  input  logic        intr_ack,
  input  logic        flags_restore,
  output logic        stall_fetch,
  output logic        inject_valid,
  output logic [15:0] inject_instr,
  output logic        pc_load_vector,
  output logic [9:0]  vector_addr,
  output logic        intr_pending,
  output logic        in_service
);

  // Last drain count value, and the ack count value from which the next
  // increment would reach ACK_TIMEOUT-1 (so re-injection lands exactly
  // ACK_TIMEOUT cycles after the previous injection).
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 2);

  intr_state_t state;
  intr_state_t next_state;
  logic [3:0]  drain_cnt;
  logic [7:0]  ack_cnt;
  logic        pending;
  logic        edge_pulse;
  logic        stall_next;
  logic        inject_next;
  logic        pc_load_next;

  intr_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .intr_in    (intr_in),
    .edge_pulse (edge_pulse)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; an RTI in the same cycle as a pending request lets
  // the request start immediately instead of losing a cycle in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (pending && (!in_service || flags_restore)) next_state = BOUNDARY;
      BOUNDARY: if (!imm_pending && !branch_taken) next_state = DRAIN;
      DRAIN:    if (drain_cnt == DRAIN_LAST) next_state = INJECT;
      INJECT:   next_state = WAIT_ACK;
      WAIT_ACK: begin
        if (intr_ack)                  next_state = VECTOR;
        else if (ack_cnt == ACK_LAST)  next_state = INJECT;
      end
      VECTOR:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they belong to.
  always_comb begin
    stall_next   = (next_state == DRAIN) || (next_state == INJECT)
                   || (next_state == WAIT_ACK);
    inject_next  = (next_state == INJECT);
    pc_load_next = (next_state == VECTOR);
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_fetch    <= 1'b0;
      inject_valid   <= 1'b0;
      pc_load_vector <= 1'b0;
    end else begin
      stall_fetch    <= stall_next;
      inject_valid   <= inject_next;
      pc_load_vector <= pc_load_next;
    end
  end

  // Drain and ack-timeout counters, both cleared whenever their state is
  // (re)entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= 4'd0;
      ack_cnt   <= 8'd0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;
      ack_cnt   <= ((state == WAIT_ACK) && (next_state == WAIT_ACK)) ? ack_cnt + 8'd1 : 8'd0;
    end
  end

  // Pending request: edges merge into one request; a fresh edge wins over
  // the clear so a request arriving on the VECTOR entry is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       pending <= 1'b0;
    else if (edge_pulse)           pending <= 1'b1;
    else if (next_state == VECTOR) pending <= 1'b0;
  end

  // Handler-running flag: set by VECTOR, cleared by RTI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                in_service <= 1'b0;
    else if (state == VECTOR) in_service <= 1'b1;
    else if (flags_restore) in_service <= 1'b0;
  end

  assign inject_instr = (state == INJECT) ? INT_WORD : 16'h0000;
  assign vector_addr  = VECTOR_ADDR;
  assign intr_pending = pending;

endmodule

// File: tb/tb_intr_sequencer.sv
// Directed bench for intr_sequencer: a vector table for the basic entry
// sequence plus hand-written multi-cycle sequences for the corner cases.
module tb_intr_sequencer;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  typedef struct {
    logic        intr, imm, br, ack, fr;
    logic        stall, injv;
    logic [15:0] instr;
    logic        pcl, pend, svc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr_in, imm_pending, branch_taken, intr_ack, flags_restore;
  logic        stall_fetch, inject_valid, pc_load_vector, intr_pending, in_service;
  logic [15:0] inject_instr;
  logic [9:0]  vector_addr;

  int total = 0;
  int bad   = 0;
  vec_t tbl[14];

  intr_sequencer #(
    .DRAIN_CYCLES (3),
    .ACK_TIMEOUT  (8),
    .VECTOR_ADDR  (10'd1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .intr_in        (intr_in),
    .imm_pending    (imm_pending),
    .branch_taken   (branch_taken),
    .intr_ack       (intr_ack),
    .flags_restore  (flags_restore),
    .stall_fetch    (stall_fetch),
    .inject_valid   (inject_valid),
    .inject_instr   (inject_instr),
    .pc_load_vector (pc_load_vector),
    .vector_addr    (vector_addr),
    .intr_pending   (intr_pending),
    .in_service     (in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic stall, input logic injv,
                             input logic [15:0] instr, input logic pcl,
                             input logic pend, input logic svc);
    checkBit({tag, ".stall_fetch"}, stall_fetch, stall);
    checkBit({tag, ".inject_valid"}, inject_valid, injv);
    checkWord({tag, ".inject_instr"}, inject_instr, instr);
    checkBit({tag, ".pc_load_vector"}, pc_load_vector, pcl);
    checkBit({tag, ".intr_pending"}, intr_pending, pend);
    checkBit({tag, ".in_service"}, in_service, svc);
  endtask

  task automatic applyStimulus(input vec_t v);
    intr_in       = v.intr;
    imm_pending   = v.imm;
    branch_taken  = v.br;
    intr_ack      = v.ack;
    flags_restore = v.fr;
  endtask

  // Raise the pin for two clocks, drop it, then wait (bounded) for pending.
  task automatic raiseAndWaitPending(input string tag);
    intr_in = 1'b1;
    tick();
    tick();
    intr_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (intr_pending) break;
    end
    checkBit({tag, ".pending_set"}, intr_pending, 1'b1);
  endtask

  initial begin
    int inj_count;
    int pcl_count;

    //          intr imm br ack fr | stall injv instr     pcl pend svc
    tbl[0]  = '{H, L, L, L, L,  L, L, 16'h0000, L, L, L};
    tbl[1]  = '{H, L, L, L, L,  L, L, 16'h0000, L, L, L};
    tbl[2]  = '{L, L, L, L, L,  L, L, 16'h0000, L, H, L};
    tbl[3]  = '{L, L, L, L, L,  L, L, 16'h0000, L, H, L};
    tbl[4]  = '{L, L, L, L, L,  H, L, 16'h0000, L, H, L};
    tbl[5]  = '{L, L, H, L, L,  H, L, 16'h0000, L, H, L};
    tbl[6]  = '{L, L, H, L, L,  H, L, 16'h0000, L, H, L};
    tbl[7]  = '{L, L, L, L, L,  H, H, 16'hC0C0, L, H, L};
    tbl[8]  = '{L, L, H, H, L,  H, L, 16'h0000, L, H, L};
    tbl[9]  = '{L, L, L, H, L,  L, L, 16'h0000, H, L, L};
    tbl[10] = '{L, L, L, L, L,  L, L, 16'h0000, L, L, H};
    tbl[11] = '{L, L, L, L, L,  L, L, 16'h0000, L, L, H};
    tbl[12] = '{L, L, L, L, H,  L, L, 16'h0000, L, L, L};
    tbl[13] = '{L, L, L, L, H,  L, L, 16'h0000, L, L, L};

    rst = 1'b1;
    intr_in = 1'b0; imm_pending = 1'b0; branch_taken = 1'b0;
    intr_ack = 1'b0; flags_restore = 1'b0;
    tick();
    tick();
    checkOutput("reset", L, L, 16'h0000, L, L, L);
    checkWord("vector_addr", {6'b0, vector_addr}, 16'h0001);
    rst = 1'b0;
    tick();
    checkOutput("post_reset", L, L, 16'h0000, L, L, L);

    $display("[TB] basic entry table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput($sformatf("vec%0d", i), tbl[i].stall, tbl[i].injv, tbl[i].instr,
                  tbl[i].pcl, tbl[i].pend, tbl[i].svc);
    end
    applyStimulus('{L, L, L, L, L, L, L, 16'h0000, L, L, L});

    $display("[TB] boundary hold and ack timeout");
    raiseAndWaitPending("hold");
    imm_pending = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkBit($sformatf("hold%0d.stall_fetch", k), stall_fetch, 1'b0);
    end
    imm_pending = 1'b0;
    tick();
    checkBit("hold_release.stall_fetch", stall_fetch, 1'b1);
    tick();
    tick();
    checkBit("hold_drain3.inject_valid", inject_valid, 1'b0);
    tick();
    checkOutput("first_inject", H, H, 16'hC0C0, L, H, L);
    for (int k = 1; k < 8; k++) begin
      tick();
      checkBit($sformatf("wait%0d.inject_valid", k), inject_valid, 1'b0);
      checkBit($sformatf("wait%0d.stall_fetch", k), stall_fetch, 1'b1);
    end
    tick();
    checkOutput("reinject", H, H, 16'hC0C0, L, H, L);
    intr_ack = 1'b1;
    tick();
    checkOutput("reinject_wait", H, L, 16'h0000, L, H, L);
    tick();
    checkOutput("reinject_vector", L, L, 16'h0000, H, L, L);
    intr_ack = 1'b0;
    tick();
    checkOutput("reinject_service", L, L, 16'h0000, L, L, H);

    $display("[TB] nesting");
    raiseAndWaitPending("nest");
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("nest_hold%0d", k), L, L, 16'h0000, L, H, H);
    end
    flags_restore = 1'b1;
    tick();
    checkOutput("nest_rti", L, L, 16'h0000, L, H, L);
    flags_restore = 1'b0;
    tick();
    checkBit("nest_drain.stall_fetch", stall_fetch, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("nest_inject", H, H, 16'hC0C0, L, H, L);
    intr_ack = 1'b1;
    tick();
    tick();
    checkOutput("nest_vector", L, L, 16'h0000, H, L, L);
    intr_ack = 1'b0;
    tick();
    checkBit("nest_service", in_service, 1'b1);
    flags_restore = 1'b1;
    tick();
    checkBit("nest_rti2", in_service, 1'b0);
    flags_restore = 1'b0;

    $display("[TB] merge");
    imm_pending = 1'b1;
    for (int k = 0; k < 3; k++) begin
      intr_in = 1'b1;
      tick();
      intr_in = 1'b0;
      tick();
    end
    tick();
    tick();
    tick();
    checkBit("merge_held.intr_pending", intr_pending, 1'b1);
    checkBit("merge_held.stall_fetch", stall_fetch, 1'b0);
    imm_pending = 1'b0;
    intr_ack = 1'b1;
    inj_count = 0;
    pcl_count = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (inject_valid) inj_count++;
      if (pc_load_vector) pcl_count++;
    end
    checkWord("merge.inject_count", 16'(inj_count), 16'd1);
    checkWord("merge.pc_load_count", 16'(pcl_count), 16'd1);
    checkBit("merge.intr_pending", intr_pending, 1'b0);
    checkBit("merge.in_service", in_service, 1'b1);
    intr_ack = 1'b0;
    flags_restore = 1'b1;
    tick();
    flags_restore = 1'b0;
    checkBit("merge_rti", in_service, 1'b0);

    $display("[TB] reset mid-sequence");
    raiseAndWaitPending("rst");
    for (int k = 0; k < 20; k++) begin
      tick();
      if (inject_valid) break;
    end
    checkBit("rst_reach_inject", inject_valid, 1'b1);
    tick();
    checkBit("rst_wait_ack.stall_fetch", stall_fetch, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rst_async", L, L, 16'h0000, L, L, L);
    tick();
    tick();
    rst = 1'b0;
    intr_ack = 1'b1;
    pcl_count = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (pc_load_vector) pcl_count++;
    end
    checkWord("rst_after.pc_load_count", 16'(pcl_count), 16'd0);
    checkOutput("rst_after", L, L, 16'h0000, L, L, L);
    intr_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
